db_ram_1p_ctrl: RTL

Initiator-side controller for the deblocking filter's single-port pixel SRAMs (20-bit × 2048 words by default). It drives the active-low cen/oen/wen/addr/data pins of one RAM. It arbitrates a write stream and a read-request stream onto that single port and returns read data through a small response FIFO with valid/ready backpressure. It sits between the DB filter datapath and each `db_ram_1p_*` instance.

---
 rtl/db_ram_1p_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/db_ram_1p_ctrl.sv
// Single-port pixel SRAM initiator: arbitrates writes and reads onto one RAM port and
// returns read data through a credit-guarded response FIFO. Define DB_RAM_CTRL_RR_EN for round-robin.
module db_ram_1p_ctrl #(
  parameter int ADDR_WIDTH = 11,
  parameter int WORD_WIDTH = 20,
  parameter int RSP_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_val_i,
  output logic                  wr_rdy_o,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [WORD_WIDTH-1:0] wr_dat_i,
  input  logic                  rd_val_i,
  output logic                  rd_rdy_o,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic                  rsp_val_o,
  input  logic                  rsp_rdy_i,
  output logic [WORD_WIDTH-1:0] rsp_dat_o,
  output logic                  ram_cen_o,
  output logic                  ram_oen_o,
  output logic                  ram_wen_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [WORD_WIDTH-1:0] ram_dat_o,
  input  logic [WORD_WIDTH-1:0] ram_dat_i
);
  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(RSP_DEPTH);

  logic [WORD_WIDTH-1:0] mem_q [RSP_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  inflight_q;
  logic [CNT_W:0]        occ_s;
  logic                  push_s, pop_s, space_ok_s;
  logic                  wr_fire_s, rd_fire_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(RSP_DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // An outstanding read already owns a FIFO slot; a pop this cycle frees one.
  assign pop_s      = rsp_val_o & rsp_rdy_i;
  assign push_s     = inflight_q;
  assign occ_s      = {1'b0, cnt_q} + {{CNT_W{1'b0}}, inflight_q};
  assign space_ok_s = (occ_s < DEPTH_L) | pop_s;

`ifdef DB_RAM_CTRL_RR_EN
  logic last_rd_q;

  always_comb begin
    wr_rdy_o = 1'b0;
    rd_rdy_o = 1'b0;
    if (rst) begin
      wr_rdy_o = 1'b0;
      rd_rdy_o = 1'b0;
    end else if (wr_val_i && rd_val_i && space_ok_s) begin
      wr_rdy_o = last_rd_q;
      rd_rdy_o = ~last_rd_q;
    end else begin
      wr_rdy_o = 1'b1;
      rd_rdy_o = ~wr_val_i & space_ok_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_rd_q <= 1'b0;
    end else if (wr_fire_s || rd_fire_s) begin
      last_rd_q <= rd_fire_s;
    end else begin
      last_rd_q <= last_rd_q;
    end
  end
`else
  assign wr_rdy_o = ~rst;
  assign rd_rdy_o = ~rst & ~wr_val_i & space_ok_s;
`endif

  assign wr_fire_s  = wr_val_i & wr_rdy_o;
  assign rd_fire_s  = rd_val_i & rd_rdy_o;

  assign ram_cen_o  = ~(wr_fire_s | rd_fire_s);
  assign ram_wen_o  = ~wr_fire_s;
  assign ram_addr_o = wr_fire_s ? wr_addr_i : rd_addr_i;
  assign ram_dat_o  = wr_dat_i;
  assign ram_oen_o  = rst;

  assign rsp_val_o  = (cnt_q != {CNT_W{1'b0}});
  assign rsp_dat_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_s) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Reset drops any read still in flight along with the queued responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= 1'b0;
      wr_ptr_q   <= {PTR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      cnt_q      <= {CNT_W{1'b0}};
    end else begin
      inflight_q <= rd_fire_s;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      mem_q[wr_ptr_q] <= ram_dat_i;
    end
  end

endmodule
